rd_requester: RTL and testbench
===============================

Name: rd_requester

Overview:
- Initiator side of the valid/ready/rdata read handshake. The responder drives `ready` and `rdata` back to a `valid` request.
- Issues a programmed burst of single-beat read requests and captures each returned `rdata`.
- Accumulates a checksum of captured data and flags a timeout if the responder stalls.
- Sits above a Middle/Inner-style responder and drives its `valid` input.

Parameters:
- DATA_W, 4, width of `rdata`.
- CNT_W, 8, width of the request count and the beat counter.
- TIMEOUT, 16, max cycles `valid` may stay high without `ready` before error; must be >= 1.
- SUM_W, 12, checksum width; wraps modulo 2^SUM_W.

Ports:
- clock  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a burst. Ignored while busy.
- num_req  input  CNT_W  beats in burst, sampled on accepted start. 0 means immediate done.
- valid  output  1  request to responder.
- ready  input  1  responder accept; transfer when valid && ready.
- rdata  input  DATA_W  responder data; sampled on transfer.
- last_data  output  DATA_W  most recently captured rdata.
- checksum  output  SUM_W  sum of all rdata captured this burst.
- beats_done  output  CNT_W  transfers completed this burst.
- busy  output  1  high in REQ/GAP.
- done  output  1  one-cycle pulse at burst completion.
- timeout_err  output  1  sticky until next accepted start.

Behaviour:
- Reset (async assert, sync-free deassert): state IDLE; all outputs 0; internal counters 0.
- States: IDLE, REQ, GAP, ERR.
- IDLE:
  - start=1 and num_req>0 → latch num_req; clear checksum, beats_done, timeout_err, wait counter; go to REQ.
  - start=1 and num_req=0 → done=1 next cycle; clear counters; stay IDLE.
- REQ:
  - valid=1, registered from the state.
  - On a cycle with ready=1: rdata → last_data; checksum += zero-extended rdata, wrapping; beats_done++; wait counter cleared.
  - If that was the final beat (beats_done+1 == latched num_req): go IDLE and pulse done the following cycle. Otherwise go to GAP.
  - ready=0: wait counter++. When it reaches TIMEOUT → ERR, valid drops next cycle.
- GAP: exactly one cycle with valid=0 between beats, so the responder sees a discrete request per beat; → REQ.
- ERR: timeout_err=1, busy=0, valid=0. start is accepted exactly as in IDLE.
- Latency: first valid appears one cycle after the start pulse; each beat takes ≥2 cycles (REQ+GAP). A 0-wait responder gives 2N-1 cycles of burst activity.
- start while busy: ignored; no effect on counters.
- ready while valid=0: ignored.
- reset_n asserted mid-burst: valid drops immediately (async); all state is lost.
- beats_done and num_req are compared at full CNT_W width; no wrap within a burst.

Optional Feature:
- Macro RD_REQ_DATA_CHECK_EN adds parameter EXP_DATA (default 4'h5) and outputs mismatch_cnt (CNT_W) and mismatch (1, sticky).
- Each transfer with rdata != EXP_DATA increments mismatch_cnt, saturating, and sets mismatch. Both clear on accepted start and on reset.
- Without the macro, these ports and that logic are absent; all other behaviour is identical.

Decomposition:
- Package rd_req_pkg: state enum type (IDLE=2'd0, REQ=2'd1, GAP=2'd2, ERR=2'd3) and default width constants.
- One natural sub-module, rd_req_timer: loadable wait counter with clear, enable and an expired flag compared against TIMEOUT.
- FSM and datapath stay in the top.

Test Plan:
- Responder ties ready=valid, rdata=4'h5; start with num_req=3 → three valid pulses separated by 1-cycle gaps; beats_done=3; checksum=15; last_data=5; done pulses once; timeout_err=0.
- num_req=0 start → done pulse one cycle later; valid never asserts; busy stays 0.
- Responder holds ready=0; num_req=2 → valid high exactly 16 cycles; then timeout_err=1, valid=0, beats_done=0. A new start clears the error.
- Responder delays ready 3 cycles per beat with rdata=4'hF, num_req=300 mod 256=44 at CNT_W=8 → checksum=660 (mod 4096); no timeout.
- Assert reset_n low during REQ of beat 2 → valid, busy, checksum and beats_done go to 0 asynchronously. Restart completes normally.
- With RD_REQ_DATA_CHECK_EN: rdata sequence 5,4,5 → mismatch_cnt=1, mismatch=1. The next start clears both.

Source files
------------

// File: rtl/rd_req_pkg.sv
// Shared types and default widths for the rd_requester read initiator.
// Contents:
//   state_t      - controller states (IDLE, REQ, GAP, ERR)
//   DEF_*        - default parameter values for the interface and top
package rd_req_pkg;

    localparam int DEF_DATA_W  = 4;
    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_SUM_W   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/rd_requester_if.sv
// valid/ready/rdata read handshake between an initiator and a responder.
// Signals:
//   valid  - request, driven by the initiator
//   ready  - accept, driven by the responder; transfer on valid && ready
//   rdata  - read data, driven by the responder, sampled on transfer
// Modports: master (initiator side), slave (responder side).
interface rd_requester_if
    import rd_req_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, input ready, input rdata);
    modport slave  (input valid, output ready, output rdata);

endinterface

// File: rtl/rd_req_timer.sv
// Wait counter for the request phase.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   clr_i          - load the counter with zero (has priority over en_i)
//   en_i           - count one stalled cycle
//   expired_o      - this enabled cycle is the TIMEOUT-th consecutive stall
module rd_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag the cycle whose increment would reach TIMEOUT, so the controller
    // leaves REQ on that same edge and valid is high exactly TIMEOUT cycles.
    assign expired_o = en_i && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/rd_requester.sv
// Read-burst initiator: issues num_req single-beat requests over the
// valid/ready/rdata handshake, with a one-cycle gap between beats, captures
// each beat, keeps a wrapping checksum and flags a responder stall.
// Ports:
//   clock, reset_n  - clock, asynchronous active-low reset
//   start, num_req  - burst launch pulse and beat count (0 = immediate done)
//   bus             - handshake (master modport)
//   last_data       - most recently captured rdata
//   checksum        - modulo 2^SUM_W sum of this burst's captured data
//   beats_done      - transfers completed this burst
//   busy, done      - burst in progress / one-cycle completion pulse
//   timeout_err     - sticky stall flag, cleared by the next accepted start
// Optional (macro RD_REQ_DATA_CHECK_EN): parameter EXP_DATA, outputs
//   mismatch_cnt (saturating) and mismatch (sticky) for beats != EXP_DATA.
module rd_requester
    import rd_req_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int SUM_W   = DEF_SUM_W
`ifdef RD_REQ_DATA_CHECK_EN
    ,
    parameter logic [DATA_W-1:0] EXP_DATA = DATA_W'(5)
`endif
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_req,
    rd_requester_if.master   bus,
    output logic [DATA_W-1:0] last_data,
    output logic [SUM_W-1:0]  checksum,
    output logic [CNT_W-1:0]  beats_done,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
`ifdef RD_REQ_DATA_CHECK_EN
    ,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              mismatch
`endif
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  beats_q, beats_d;
    logic [CNT_W-1:0]  beats_inc;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              done_q, done_d;
    logic              terr_q, terr_d;
    logic              tmr_clr, tmr_en, tmr_expired;
`ifdef RD_REQ_DATA_CHECK_EN
    logic [CNT_W-1:0]  mm_cnt_q, mm_cnt_d;
    logic              mm_q, mm_d;
`endif

    rd_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign beats_inc = beats_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        beats_d  = beats_q;
        sum_d    = sum_q;
        last_d   = last_q;
        done_d   = 1'b0;
        terr_d   = terr_q;
        tmr_clr  = 1'b0;
        tmr_en   = 1'b0;
`ifdef RD_REQ_DATA_CHECK_EN
        mm_cnt_d = mm_cnt_q;
        mm_d     = mm_q;
`endif
        case (state_q)
            // ERR accepts a new burst exactly like IDLE does.
            IDLE, ERR: begin
                if (start) begin
                    beats_d = '0;
                    sum_d   = '0;
                    terr_d  = 1'b0;
                    tmr_clr = 1'b1;
`ifdef RD_REQ_DATA_CHECK_EN
                    mm_cnt_d = '0;
                    mm_d     = 1'b0;
`endif
                    if (num_req == '0) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        num_d   = num_req;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (bus.ready) begin
                    last_d  = bus.rdata;
                    sum_d   = sum_q + SUM_W'(bus.rdata);
                    beats_d = beats_inc;
                    tmr_clr = 1'b1;
`ifdef RD_REQ_DATA_CHECK_EN
                    if (bus.rdata != EXP_DATA) begin
                        mm_d = 1'b1;
                        if (mm_cnt_q != '1) begin
                            mm_cnt_d = mm_cnt_q + 1'b1;
                        end
                    end
`endif
                    if (beats_inc == num_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_expired) begin
                        terr_d  = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            // One idle cycle so every beat is a distinct request.
            GAP: state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            num_q    <= '0;
            beats_q  <= '0;
            sum_q    <= '0;
            last_q   <= '0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
`ifdef RD_REQ_DATA_CHECK_EN
            mm_cnt_q <= '0;
            mm_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            beats_q  <= beats_d;
            sum_q    <= sum_d;
            last_q   <= last_d;
            done_q   <= done_d;
            terr_q   <= terr_d;
`ifdef RD_REQ_DATA_CHECK_EN
            mm_cnt_q <= mm_cnt_d;
            mm_q     <= mm_d;
`endif
        end
    end

    // valid decodes the state register directly, so it drops the moment
    // reset_n is asserted.
    assign bus.valid   = (state_q == REQ);
    assign busy        = (state_q == REQ) || (state_q == GAP);
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign last_data   = last_q;
    assign checksum    = sum_q;
    assign beats_done  = beats_q;
`ifdef RD_REQ_DATA_CHECK_EN
    assign mismatch_cnt = mm_cnt_q;
    assign mismatch     = mm_q;
`endif

endmodule

// File: tb/tb_rd_requester.sv
module tb_rd_requester;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_req = 8'd0;
    logic [3:0] last_data;
    logic [11:0] checksum;
    logic [7:0] beats_done;
    logic       busy, done, timeout_err;
`ifdef RD_REQ_DATA_CHECK_EN
    logic [7:0] mismatch_cnt;
    logic       mismatch;
`endif

    rd_requester_if #(.DATA_W(4)) ifc ();

    rd_requester dut (
        .clock       (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_req     (num_req),
        .bus         (ifc),
        .last_data   (last_data),
        .checksum    (checksum),
        .beats_done  (beats_done),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
`ifdef RD_REQ_DATA_CHECK_EN
        ,
        .mismatch_cnt(mismatch_cnt),
        .mismatch    (mismatch)
`endif
    );

    always #5 clk = ~clk;

    // Responder: beat b waits dly_tab[b] stalled cycles, then returns dat_tab[b].
    int         dly_tab [256];
    logic [3:0] dat_tab [256];
    int         xfer_cnt = 0;
    int         base = 0;
    int         wcnt = 0;
    int         idx;

    always_comb idx = (xfer_cnt - base) & 255;
    assign ifc.ready = ifc.valid && (wcnt >= dly_tab[idx]);
    assign ifc.rdata = dat_tab[idx];

    always @(posedge clk) begin
        if (ifc.valid && !ifc.ready) wcnt <= wcnt + 1;
        else                         wcnt <= 0;
        if (ifc.valid && ifc.ready)  xfer_cnt <= xfer_cnt + 1;
    end

    // Cumulative observation counters, sampled away from the active edge.
    int vcnt = 0;
    int dcnt = 0;
    always @(negedge clk) begin
        if (ifc.valid) vcnt <= vcnt + 1;
        if (done)      dcnt <= dcnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] mdl_last = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fill_const(input int dly, input int dat);
        for (int b = 0; b < 256; b++) begin
            dly_tab[b] = dly;
            dat_tab[b] = dat[3:0];
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after start.
    task automatic start_pulse(input int num);
        base    = xfer_cnt;
        start   = 1'b1;
        num_req = num[7:0];
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic run_burst(input int num, input bit inj,
                             output int r_beats, output int r_sum, output int r_last,
                             output int r_terr, output int r_vcyc, output int r_done);
        int v0, d0, cyc;
        bit fin;
        @(negedge clk);
        v0 = vcnt;
        d0 = dcnt;
        start_pulse(num);
        chk("first_valid", ifc.valid, 1);
        chk("first_busy", busy, 1);
        chk("err_cleared", timeout_err, 0);
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            if (inj && cyc == 3) begin
                start   = 1'b1;
                num_req = 8'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (done || timeout_err) fin = 1'b1;
        end
        start = 1'b0;
        if (!fin) begin
            n_vec++;
            n_err++;
            $display("FAIL burst_end: no done/timeout_err within %0d cycles", cyc);
        end
        chk("end_busy", busy, 0);
        chk("end_valid", ifc.valid, 0);
        @(negedge clk);
        @(negedge clk);
        r_beats = int'(beats_done);
        r_sum   = int'(checksum);
        r_last  = int'(last_data);
        r_terr  = int'(timeout_err);
        r_vcyc  = vcnt - v0;
        r_done  = dcnt - d0;
    endtask

    // Reference: walk the beats with the responder's per-beat stall counts.
    task automatic model(input int num, output int beats, output int sum, output int last,
                         output int terr, output int vcyc, output int dn);
        beats = 0; sum = 0; last = int'(mdl_last); terr = 0; vcyc = 0;
        for (int b = 0; b < num; b++) begin
            if (dly_tab[b] >= TMO) begin
                terr = 1;
                vcyc += TMO;
                break;
            end
            vcyc += dly_tab[b] + 1;
            sum = (sum + int'(dat_tab[b])) % 4096;
            beats++;
            last = int'(dat_tab[b]);
        end
        dn = terr ? 0 : 1;
    endtask

    task automatic run_model_check(input int num, input bit inj, input string tag);
        int eb, es, el, et, ev, ed;
        int ob, os, ol, ot, ov, od;
        model(num, eb, es, el, et, ev, ed);
        run_burst(num, inj, ob, os, ol, ot, ov, od);
        chk({tag, "_beats"}, ob, eb);
        chk({tag, "_sum"}, os, es);
        chk({tag, "_last"}, ol, el);
        chk({tag, "_terr"}, ot, et);
        chk({tag, "_vcyc"}, ov, ev);
        chk({tag, "_done"}, od, ed);
        mdl_last = el[3:0];
    endtask

    typedef struct {
        int num; int dly; int dat;
        int beats; int sum; int last; int terr; int vcyc;
    } vec_t;
    vec_t tab [7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] vpat, dpat;
        int ob, os, ol, ot, ov, od, k, num;
        bit found;

        tab[0] = '{3,   0,   5, 3,   15,   5,  0, 3};
        tab[1] = '{2,   100, 3, 0,   0,    5,  1, 16};
        tab[2] = '{44,  3,   15, 44, 660,  15, 0, 176};
        tab[3] = '{1,   15,  7, 1,   7,    7,  0, 16};
        tab[4] = '{1,   16,  9, 0,   0,    7,  1, 16};
        tab[5] = '{255, 0,   15, 255, 3825, 15, 0, 255};
        tab[6] = '{3,   2,   12, 3,  36,   12, 0, 9};
        fill_const(0, 5);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", ifc.valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_sum", checksum, 0);
        chk("rst_beats", beats_done, 0);
        chk("rst_last", last_data, 0);
        reset_n = 1'b1;

        // Zero-wait burst of 3: valid pattern REQ,GAP,REQ,GAP,REQ then done
        @(negedge clk);
        start_pulse(3);
        vpat = {5'b0, ifc.valid};
        dpat = {5'b0, done};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vpat = {vpat[4:0], ifc.valid};
            dpat = {dpat[4:0], done};
        end
        chk("gap_pattern", vpat, 6'b101010);
        chk("done_pattern", dpat, 6'b000001);
        chk("b3_beats", beats_done, 3);
        chk("b3_sum", checksum, 15);
        chk("b3_last", last_data, 5);
        chk("b3_terr", timeout_err, 0);

        // num_req = 0: done next cycle, counters cleared, no request
        @(negedge clk);
        start_pulse(0);
        chk("z_done", done, 1);
        chk("z_valid", ifc.valid, 0);
        chk("z_busy", busy, 0);
        chk("z_beats", beats_done, 0);
        chk("z_sum", checksum, 0);
        @(negedge clk);
        chk("z_done_clear", done, 0);

        // Table of constant-responder bursts
        for (int i = 0; i < 7; i++) begin
            fill_const(tab[i].dly, tab[i].dat);
            run_burst(tab[i].num, 1'b0, ob, os, ol, ot, ov, od);
            chk($sformatf("row%0d_beats", i), ob, tab[i].beats);
            chk($sformatf("row%0d_sum", i), os, tab[i].sum);
            chk($sformatf("row%0d_last", i), ol, tab[i].last);
            chk($sformatf("row%0d_terr", i), ot, tab[i].terr);
            chk($sformatf("row%0d_vcyc", i), ov, tab[i].vcyc);
            chk($sformatf("row%0d_done", i), od, tab[i].terr ? 0 : 1);
        end
        mdl_last = 4'hC;

        // start while busy is ignored
        fill_const(2, 6);
        run_model_check(6, 1'b1, "busy_start");

        // Asynchronous reset during REQ of beat 2
        fill_const(0, 5);
        @(negedge clk);
        start_pulse(3);
        found = 1'b0;
        k = 0;
        while (!found && k < 10) begin
            if (beats_done == 8'd1 && ifc.valid) found = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk("rst_mid_reached", found, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstm_valid", ifc.valid, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_sum", checksum, 0);
        chk("rstm_beats", beats_done, 0);
        chk("rstm_last", last_data, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mdl_last = 4'h0;
        for (int b = 0; b < 256; b++) dat_tab[b] = 4'($urandom_range(0, 15));
        run_model_check(4, 1'b0, "restart");

        // Randomized bursts with occasional stalls long enough to time out
        for (int it = 0; it < 40; it++) begin
            num = $urandom_range(1, 20);
            for (int b = 0; b < 256; b++) begin
                dat_tab[b] = 4'($urandom_range(0, 15));
                dly_tab[b] = ($urandom_range(0, 19) == 0) ? $urandom_range(16, 20)
                                                          : $urandom_range(0, 4);
            end
            run_model_check(num, 1'b0, $sformatf("rnd%0d", it));
        end

`ifdef RD_REQ_DATA_CHECK_EN
        fill_const(0, 5);
        dat_tab[1] = 4'h4;
        run_burst(3, 1'b0, ob, os, ol, ot, ov, od);
        chk("mm_cnt", mismatch_cnt, 1);
        chk("mm_flag", mismatch, 1);
        fill_const(0, 5);
        run_burst(2, 1'b0, ob, os, ol, ot, ov, od);
        chk("mm_cnt_clear", mismatch_cnt, 0);
        chk("mm_flag_clear", mismatch, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
